// File: rtl/timer_multi_compare_if.sv
// Channel programming bundle for timer_multi_compare: arm/re-arm write plus
// per-channel cancel and flag-clear masks.
interface timer_multi_compare_if #(
    parameter int N  = 16,
    parameter int CH = 4
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic          wr_en;
    logic [CW-1:0] wr_ch;
    logic [N-1:0]  wr_delay;
    logic          wr_periodic;
    logic [CH-1:0] cancel;
    logic [CH-1:0] flag_clr;

    modport master (
        output wr_en, wr_ch, wr_delay, wr_periodic, cancel, flag_clr
    );

    modport slave (
        input wr_en, wr_ch, wr_delay, wr_periodic, cancel, flag_clr
    );
endinterface

// File: rtl/timer_multi_compare.sv
// Shared prescaled timestamp counter with CH independent compare channels,
// each one-shot or periodic, with match pulse, sticky flag and overrun.
module timer_multi_compare #(
    parameter int N  = 16,
    parameter int CH = 4,
    parameter int P  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [P-1:0]        prescale,
    timer_multi_compare_if.slave cfg,
    output logic [N-1:0]        timestamp,
    output logic [CH-1:0]       match,
    output logic [CH-1:0]       flag,
    output logic [CH-1:0]       overrun,
    output logic [CH-1:0]       armed
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic [P-1:0]  pcnt;
    logic          tick;
    logic [N-1:0]  ts_next;
    logic [N-1:0]  target [CH];
    logic [N-1:0]  period [CH];
    logic [CH-1:0] periodic;
    logic [CH-1:0] wr_hit;
    logic [CH-1:0] hit;

    // >= rather than == so a prescale reduction below pcnt fires immediately
    assign tick    = en && (pcnt >= prescale);
    assign ts_next = timestamp + 1'b1;

    always_comb begin
        wr_hit = '0;
        hit    = '0;
        for (int i = 0; i < CH; i++) begin
            wr_hit[i] = cfg.wr_en && (cfg.wr_ch == CW'(i));
            hit[i]    = tick && armed[i] && (ts_next == target[i])
                        && !wr_hit[i] && !cfg.cancel[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt      <= '0;
            timestamp <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick)
                timestamp <= ts_next;
        end
    end

    // Delay 0 leaves target == timestamp, which naturally matches after a full wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CH; i++) begin
                target[i] <= '0;
                period[i] <= '0;
            end
            periodic <= '0;
            armed    <= '0;
            match    <= '0;
            flag     <= '0;
            overrun  <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                match[i] <= hit[i];

                if (wr_hit[i]) begin
                    target[i]   <= timestamp + cfg.wr_delay;
                    period[i]   <= cfg.wr_delay;
                    periodic[i] <= cfg.wr_periodic;
                    armed[i]    <= 1'b1;
                end else if (cfg.cancel[i]) begin
                    armed[i] <= 1'b0;
                end else if (hit[i]) begin
                    if (periodic[i])
                        target[i] <= target[i] + period[i];
                    else
                        armed[i] <= 1'b0;
                end

                // A match beats a same-cycle clear, but a clear still suppresses overrun
                if (hit[i]) begin
                    flag[i] <= 1'b1;
                    if (cfg.flag_clr[i])
                        overrun[i] <= 1'b0;
                    else if (flag[i])
                        overrun[i] <= 1'b1;
                end else if (cfg.flag_clr[i]) begin
                    flag[i]    <= 1'b0;
                    overrun[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_timer_multi_compare.sv
// Directed bench for timer_multi_compare: prescaler, one-shot, periodic,
// overrun, simultaneous events, wrap and enable gating.
module tb_timer_multi_compare;
    localparam int N  = 16;
    localparam int CH = 4;
    localparam int P  = 8;

    logic          clk;
    logic          reset;
    logic          en;
    logic [P-1:0]  prescale;
    logic [N-1:0]  timestamp;
    logic [CH-1:0] match;
    logic [CH-1:0] flag;
    logic [CH-1:0] overrun;
    logic [CH-1:0] armed;
    logic [CH-1:0] seen;

    int n_total = 0;
    int n_pass  = 0;

    timer_multi_compare_if #(.N(N), .CH(CH)) cfg ();

    timer_multi_compare #(.N(N), .CH(CH), .P(P)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .prescale  (prescale),
        .cfg       (cfg),
        .timestamp (timestamp),
        .match     (match),
        .flag      (flag),
        .overrun   (overrun),
        .armed     (armed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic write_ch(input int ch, input logic [N-1:0] dly, input logic per);
        cfg.wr_en       = 1'b1;
        cfg.wr_ch       = 2'(ch);
        cfg.wr_delay    = dly;
        cfg.wr_periodic = per;
    endtask

    initial begin
        reset = 1'b0;
        en = 1'b0;
        prescale = '0;
        cfg.wr_en = 1'b0;
        cfg.wr_ch = '0;
        cfg.wr_delay = '0;
        cfg.wr_periodic = 1'b0;
        cfg.cancel = '0;
        cfg.flag_clr = '0;
        seen = '0;

        cyc(3);
        chk("rst_ts", 32'(timestamp), 32'h0);
        chk("rst_outs", {match, flag, overrun, armed}, 32'h0);

        // prescale = 2: one tick every 3 enabled cycles
        reset = 1'b1; en = 1'b1; prescale = 8'd2;
        cyc(3); chk("ps_ts1", 32'(timestamp), 32'd1);
        cyc(3); chk("ps_ts2", 32'(timestamp), 32'd2);
        cyc(3); chk("ps_ts3", 32'(timestamp), 32'd3);

        // async reset in mid-count
        cyc(1);
        reset = 1'b0;
        #1;
        chk("rst_async_ts", 32'(timestamp), 32'h0);
        cyc(2);
        chk("rst_hold_ts", 32'(timestamp), 32'h0);
        chk("rst_hold_outs", {match, flag, overrun, armed}, 32'h0);
        reset = 1'b1;
        cyc(2); chk("ps_rel_ts0", 32'(timestamp), 32'd0);
        cyc(1); chk("ps_rel_ts1", 32'(timestamp), 32'd1);

        // one-shot ch0: delay 5 from ts 10
        prescale = 8'd0;
        cyc(9); chk("os_ts10", 32'(timestamp), 32'd10);
        write_ch(0, 16'd5, 1'b0);
        cyc(1); cfg.wr_en = 1'b0;
        chk("os_armed", 32'(armed), 32'h1);
        cyc(3); chk("os_early", 32'(match), 32'h0);
        cyc(1);
        chk("os_ts15", 32'(timestamp), 32'd15);
        chk("os_match", 32'(match), 32'h1);
        chk("os_flag", 32'(flag), 32'h1);
        chk("os_disarm", 32'(armed), 32'h0);
        cyc(1); chk("os_pulse1", 32'(match), 32'h0);

        // periodic ch1: delay 4 from ts 0
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        write_ch(1, 16'd4, 1'b1);
        cyc(1); cfg.wr_en = 1'b0;
        chk("per_ts1", 32'(timestamp), 32'd1);
        cyc(3);
        chk("per_m4", {timestamp, 12'h0, match}, {16'd4, 12'h0, 4'b0010});
        chk("per_ov4", 32'(overrun), 32'h0);
        cyc(4);
        chk("per_m8", {timestamp, 12'h0, match}, {16'd8, 12'h0, 4'b0010});
        chk("per_ov8", 32'(overrun), 32'b0010);
        cyc(4);
        chk("per_m12", {timestamp, 12'h0, match}, {16'd12, 12'h0, 4'b0010});
        chk("per_armed", 32'(armed), 32'b0010);
        cfg.flag_clr = 4'b0010;
        cyc(1);
        chk("clr_flag", 32'(flag), 32'h0);
        chk("clr_ov", 32'(overrun), 32'h0);

        // ch2 periodic delay 3 from ts 13: matches at 16 alongside ch1, then 19
        cfg.flag_clr = '0;
        write_ch(2, 16'd3, 1'b1);
        cyc(1); cfg.wr_en = 1'b0;
        cyc(2);
        chk("sim_m16", {timestamp, 12'h0, match}, {16'd16, 12'h0, 4'b0110});
        cyc(2);
        cfg.flag_clr = 4'b0100;
        cyc(1);
        cfg.flag_clr = '0;
        chk("clr_win_m", {timestamp, 12'h0, match}, {16'd19, 12'h0, 4'b0100});
        chk("clr_win_flag", 32'(flag[2]), 32'h1);
        chk("clr_win_ov", 32'(overrun[2]), 32'h0);

        // write beats cancel on ch3; plain cancel on ch2
        write_ch(3, 16'd5, 1'b0);
        cfg.cancel = 4'b1100;
        cyc(1);
        cfg.wr_en = 1'b0; cfg.cancel = '0;
        chk("wr_vs_cancel", 32'(armed), 32'b1010);

        // enable gating with prescale = 1, frozen mid-count
        prescale = 8'd1;
        cyc(1);
        en = 1'b0;
        seen = '0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            seen |= match;
        end
        chk("gate_ts", 32'(timestamp), 32'd20);
        chk("gate_quiet", 32'(seen), 32'h0);
        en = 1'b1;
        seen = '0;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            seen |= match;
        end
        chk("gate_ts23", 32'(timestamp), 32'd23);
        chk("gate_cancel_quiet", 32'(seen), 32'h0);
        cyc(1);
        chk("gate_m24", {timestamp, 12'h0, match}, {16'd24, 12'h0, 4'b1010});

        // disarm and clear everything
        prescale = 8'd0;
        cfg.cancel = 4'hF;
        cfg.flag_clr = 4'hF;
        cyc(1);
        cfg.cancel = '0; cfg.flag_clr = '0;
        chk("all_disarm", {timestamp, 4'h0, armed, flag, overrun}, {16'd25, 16'h0});

        // delay 0 on ch3 at ts 25: match after exactly 2^16 ticks
        write_ch(3, 16'd0, 1'b0);
        cyc(1); cfg.wr_en = 1'b0;
        chk("d0_armed", {timestamp, 12'h0, armed}, {16'd26, 12'h0, 4'b1000});
        seen = '0;
        for (int k = 0; k < 65508; k++) begin
            cyc(1);
            seen |= match;
        end
        chk("wrap_quiet", 32'(seen), 32'h0);
        chk("wrap_fffe", 32'(timestamp), 32'hFFFE);
        write_ch(2, 16'd4, 1'b0);
        cyc(1); cfg.wr_en = 1'b0;
        cyc(2);
        chk("wrap_early", {timestamp, 12'h0, match}, {16'd1, 12'h0, 4'b0000});
        cyc(1);
        chk("wrap_m2", {timestamp, 12'h0, match}, {16'd2, 12'h0, 4'b0100});
        seen = '0;
        for (int k = 0; k < 22; k++) begin
            cyc(1);
            seen |= match;
        end
        chk("d0_quiet", 32'(seen), 32'h0);
        cyc(1);
        chk("d0_match", {timestamp, 12'h0, match}, {16'd25, 12'h0, 4'b1000});
        chk("final_armed", 32'(armed), 32'h0);
        cyc(1);
        chk("final_pulse", 32'(match), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
